// File: rtl/oerv_immdec_par_if.sv
// oerv_immdec_par_if: fetch/decode bus between the core and the parallel immediate decoder.
interface oerv_immdec_par_if #(parameter int W = 8);
   logic          i_wb_en;
   logic [31:7]   i_wb_rdt;
   logic [2:0]    i_imm_fmt;
   logic          i_csr_imm_en;
   logic          i_cnt_en;
   logic          i_cnt_done;
   logic [4:0]    o_rd_addr;
   logic [4:0]    o_rs1_addr;
   logic [4:0]    o_rs2_addr;
   logic [W-1:0]  o_imm;
   logic [W-1:0]  o_csr_imm;
   logic          o_last;
   logic          o_misalign;
   modport master (
      output i_wb_en, i_wb_rdt, i_imm_fmt, i_csr_imm_en, i_cnt_en, i_cnt_done,
      input  o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm, o_csr_imm, o_last, o_misalign
   );
   modport slave (
      input  i_wb_en, i_wb_rdt, i_imm_fmt, i_csr_imm_en, i_cnt_en, i_cnt_done,
      output o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm, o_csr_imm, o_last, o_misalign
   );
endinterface

// File: rtl/oerv_immdec_par.sv
// oerv_immdec_par: RV32I immediate/zimm decoder delivering W bits per beat, LSB first.
module oerv_immdec_par #(
   parameter int W = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   oerv_immdec_par_if.slave bus
);
   localparam int C = 32 / W;
   localparam int BW = $clog2(C);
   localparam logic [BW-1:0] LAST = BW'(C - 1);
   typedef enum logic [1:0] {IDLE, READY, SHIFT, DRAINED} state_t;
   state_t        state, state_n;
   logic [BW-1:0] beat, beat_n;
   logic [31:7]   raw, raw_n;
   logic [31:0]   s, s_n, cs, cs_n, dec, zimm;
   logic          fill, fill_n, dfill, mis, mis_n, at_end, active;
   always_comb begin
      dec = '0;
      case (bus.i_imm_fmt)
         3'b000: dec = {{20{raw[31]}}, raw[31:20]};
         3'b001: dec = {{20{raw[31]}}, raw[31:25], raw[11:7]};
         3'b010: dec = {{20{raw[31]}}, raw[7], raw[30:25], raw[11:8], 1'b0};
         3'b011: dec = {raw[31:12], 12'b0};
         3'b100: dec = {{12{raw[31]}}, raw[19:12], raw[20], raw[30:21], 1'b0};
         default: dec = '0;
      endcase
   end
   // U is the only format whose upper bits are not a sign extension
   assign dfill  = (bus.i_imm_fmt != 3'b011) & dec[31];
   assign zimm   = {27'b0, raw[19:15]};
   assign at_end = beat == LAST;
   assign active = state == READY || state == SHIFT;
   always_comb begin
      state_n = state;
      beat_n  = beat;
      raw_n   = raw;
      s_n     = s;
      cs_n    = cs;
      fill_n  = fill;
      mis_n   = mis;
      if (bus.i_wb_en) begin
         raw_n   = bus.i_wb_rdt;
         beat_n  = '0;
         s_n     = '0;
         cs_n    = '0;
         fill_n  = 1'b0;
         mis_n   = 1'b0;
         state_n = READY;
      end else if (bus.i_cnt_en && active) begin
         mis_n   = mis | (bus.i_cnt_done & ~at_end);
         beat_n  = at_end ? beat : beat + 1'b1;
         state_n = at_end ? DRAINED : SHIFT;
         fill_n  = state == READY ? dfill : fill;
         s_n     = state == READY ? {{W{dfill}}, dec[31:W]} : {{W{fill}}, s[31:W]};
         cs_n    = state == READY ? {{W{1'b0}}, zimm[31:W]} : {{W{1'b0}}, cs[31:W]};
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         beat  <= '0;
         raw   <= '0;
         s     <= '0;
         cs    <= '0;
         fill  <= 1'b0;
         mis   <= 1'b0;
      end else begin
         state <= state_n;
         beat  <= beat_n;
         raw   <= raw_n;
         s     <= s_n;
         cs    <= cs_n;
         fill  <= fill_n;
         mis   <= mis_n;
      end
   end
   assign bus.o_rd_addr  = raw[11:7];
   assign bus.o_rs1_addr = raw[19:15];
   assign bus.o_rs2_addr = raw[24:20];
   assign bus.o_imm      = state == READY   ? dec[W-1:0] :
                           state == SHIFT   ? s[W-1:0]   :
                           state == DRAINED ? {W{fill}}  : '0;
   assign bus.o_csr_imm  = !bus.i_csr_imm_en ? '0         :
                           state == READY    ? zimm[W-1:0] :
                           state == SHIFT    ? cs[W-1:0]   : '0;
   assign bus.o_last     = active && at_end;
   assign bus.o_misalign = mis;
endmodule

// File: tb/tb_oerv_immdec_par.sv
// tb_oerv_immdec_par: directed vectors for the W=8, W=4 and W=1 decoder builds.
module tb_oerv_immdec_par;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] instr;
   logic [7:0] e1 [4] = '{8'h23, 8'h01, 8'h00, 8'h00};
   logic [7:0] e2 [4] = '{8'h00, 8'hE0, 8'hCD, 8'hAB};
   logic [3:0] e5 [8] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
   always #5 clk = ~clk;
   oerv_immdec_par_if #(.W(8)) b8 ();
   oerv_immdec_par_if #(.W(4)) b4 ();
   oerv_immdec_par_if #(.W(1)) b1 ();
   oerv_immdec_par #(.W(8)) u8 (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
   oerv_immdec_par #(.W(4)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
   oerv_immdec_par #(.W(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic step8;
      b8.i_cnt_en = 1'b1;
      tick();
      b8.i_cnt_en = 1'b0;
   endtask
   task automatic load8(input logic [31:0] ins, input logic [2:0] fmt);
      b8.i_wb_rdt = ins[31:7];
      b8.i_imm_fmt = fmt;
      b8.i_wb_en = 1'b1;
      tick();
      b8.i_wb_en = 1'b0;
   endtask
   initial begin
      {b8.i_wb_en, b8.i_wb_rdt, b8.i_imm_fmt, b8.i_csr_imm_en, b8.i_cnt_en, b8.i_cnt_done} = '0;
      {b4.i_wb_en, b4.i_wb_rdt, b4.i_imm_fmt, b4.i_csr_imm_en, b4.i_cnt_en, b4.i_cnt_done} = '0;
      {b1.i_wb_en, b1.i_wb_rdt, b1.i_imm_fmt, b1.i_csr_imm_en, b1.i_cnt_en, b1.i_cnt_done} = '0;
      tick();
      tick();
      check("rst_imm", b8.o_imm, 0);
      check("rst_rd", b8.o_rd_addr, 0);
      check("rst_last", b8.o_last, 0);
      check("rst_mis", b8.o_misalign, 0);
      rst_n = 1'b1;
      b8.i_csr_imm_en = 1'b1;
      step8();
      check("idle_imm", b8.o_imm, 0);
      check("idle_csr", b8.o_csr_imm, 0);
      // addi x1, x0, 0x123
      instr = 32'h12300093;
      load8(instr, 3'b000);
      check("s1_rd", b8.o_rd_addr, 1);
      check("s1_rs1", b8.o_rs1_addr, 0);
      check("s1_rs2", b8.o_rs2_addr, 3);
      for (int k = 0; k < 4; k++) begin
         check("s1_imm", b8.o_imm, e1[k]);
         check("s1_last", b8.o_last, k == 3);
         step8();
      end
      check("s1_drain", b8.o_imm, 0);
      check("s1_drain_last", b8.o_last, 0);
      // lui x5, 0xABCDE
      load8(32'hABCDE2B7, 3'b011);
      check("s2_rd", b8.o_rd_addr, 5);
      for (int k = 0; k < 4; k++) begin
         check("s2_imm", b8.o_imm, e2[k]);
         step8();
      end
      check("s2_drain", b8.o_imm, 0);
      step8();
      check("s2_drain_hold", b8.o_imm, 0);
      // sw x0, -8(x0); format flipped to U after the first beat
      load8(32'hFE002C23, 3'b001);
      check("s3_imm0", b8.o_imm, 8'hF8);
      step8();
      b8.i_imm_fmt = 3'b011;
      for (int k = 1; k < 4; k++) begin
         check("s3_imm", b8.o_imm, 8'hFF);
         step8();
      end
      check("s3_drain", b8.o_imm, 8'hFF);
      step8();
      check("s3_drain_hold", b8.o_imm, 8'hFF);
      // csrrwi x1, 0x340, 0x1F on the bit-serial build
      instr = 32'h340FD0F3;
      for (int pass = 0; pass < 2; pass++) begin
         b1.i_wb_rdt = instr[31:7];
         b1.i_csr_imm_en = pass == 0;
         b1.i_wb_en = 1'b1;
         tick();
         b1.i_wb_en = 1'b0;
         check("s4_rs1", b1.o_rs1_addr, 5'h1F);
         for (int k = 0; k < 32; k++) begin
            check(pass == 0 ? "s4_csr_on" : "s4_csr_off", b1.o_csr_imm, pass == 0 && k < 5);
            check("s4_last", b1.o_last, k == 31);
            b1.i_cnt_en = 1'b1;
            tick();
            b1.i_cnt_en = 1'b0;
         end
         check("s4_drain_csr", b1.o_csr_imm, 0);
      end
      // addi x0, x0, -1 on the nibble build, premature cnt_done at beat 2
      instr = 32'hFFF00013;
      b4.i_wb_rdt = instr[31:7];
      b4.i_wb_en = 1'b1;
      tick();
      b4.i_wb_en = 1'b0;
      b4.i_cnt_en = 1'b1;
      tick();
      tick();
      b4.i_cnt_en = 1'b0;
      check("s5_imm_b2", b4.o_imm, 4'hF);
      check("s5_mis_pre", b4.o_misalign, 0);
      b4.i_cnt_en = 1'b1;
      b4.i_cnt_done = 1'b1;
      tick();
      b4.i_cnt_done = 1'b0;
      check("s5_mis_set", b4.o_misalign, 1);
      tick();
      b4.i_cnt_en = 1'b0;
      tick();
      check("s5_mis_hold", b4.o_misalign, 1);
      instr = 32'h12300093;
      b4.i_wb_rdt = instr[31:7];
      b4.i_wb_en = 1'b1;
      b4.i_cnt_en = 1'b1;
      tick();
      b4.i_wb_en = 1'b0;
      b4.i_cnt_en = 1'b0;
      check("s5_mis_clr", b4.o_misalign, 0);
      check("s5_wb_wins", b4.o_imm, 4'h3);
      check("s5_wb_last", b4.o_last, 0);
      for (int k = 1; k < 8; k++) begin
         b4.i_cnt_en = 1'b1;
         tick();
         b4.i_cnt_en = 1'b0;
         check("s5_imm", b4.o_imm, e5[k]);
      end
      check("s5_last", b4.o_last, 1);
      b4.i_cnt_en = 1'b1;
      b4.i_cnt_done = 1'b1;
      tick();
      b4.i_cnt_en = 1'b0;
      b4.i_cnt_done = 1'b0;
      check("s5_done_ok", b4.o_misalign, 0);
      check("s5_drain_last", b4.o_last, 0);
      // reset pulled in the middle of a W=8 sequence
      load8(32'hABCDE2B7, 3'b011);
      step8();
      step8();
      check("s6_imm_b2", b8.o_imm, 8'hCD);
      #2 rst_n = 1'b0;
      #1;
      check("s6_rst_imm", b8.o_imm, 0);
      check("s6_rst_rd", b8.o_rd_addr, 0);
      check("s6_rst_csr", b8.o_csr_imm, 0);
      tick();
      rst_n = 1'b1;
      step8();
      step8();
      check("s6_idle_imm", b8.o_imm, 0);
      check("s6_idle_last", b8.o_last, 0);
      load8(32'h12300093, 3'b000);
      check("s6_reload_imm", b8.o_imm, 8'h23);
      check("s6_reload_rd", b8.o_rd_addr, 1);
      step8();
      check("s6_reload_b1", b8.o_imm, 8'h01);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/oerv_immdec_par.md
OERV_IMMDEC_PAR -- requirements
Module: oerv_immdec_par

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter W, default 8, SHALL set the immediate bits delivered per beat (legal values 1, 2, 4, 8).
REQ-003 Derived constant C = 32/W SHALL be the number of beats per immediate; beat counter width SHALL be log2(C).
REQ-004 Ports SHALL be:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_en  in  1  instruction fetch strobe
- i_wb_rdt  in  25 [31:7]  fetched instruction bits
- i_imm_fmt  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; others give a zero immediate
- i_csr_imm_en  in  1  enables the CSR zimm output
- i_cnt_en  in  1  beat advance
- i_cnt_done  in  1  core marks final beat
- o_rd_addr  out  5  instr[11:7]
- o_rs1_addr  out  5  instr[19:15]
- o_rs2_addr  out  5  instr[24:20]
- o_imm  out  W  current immediate slice, LSB first
- o_csr_imm  out  W  current zimm slice
- o_last  out  1  current beat is C-1
- o_misalign  out  1  sticky beat/cnt_done mismatch

Function
REQ-005 On i_wb_en, the block SHALL capture instr[31:7] into a raw register, set rd/rs1/rs2 addresses, clear beat to 0, clear o_misalign, and enter READY.
REQ-006 States SHALL be IDLE (no instruction), READY (beat 0, unshifted), SHIFT (beats 1..C-1) and DRAINED (all beats consumed).
REQ-007 The decoded 32-bit immediate SHALL follow RV32I rules:
- I: sext(i[31:20])
- S: sext({i[31:25],i[11:7]})
- B: sext({i[31],i[7],i[30:25],i[11:8],0})
- U: {i[31:12],12'b0}
- J: sext({i[31],i[19:12],i[20],i[30:21],0})
REQ-008 In READY, o_imm SHALL be decoded[W-1:0], computed combinationally from the raw register and the live i_imm_fmt.
REQ-009 On i_cnt_en in READY, the block SHALL load shift register S with decoded>>W (sign-filled, U zero-filled), set beat to 1, and enter SHIFT.
REQ-010 In SHIFT, o_imm SHALL equal S[W-1:0]; each i_cnt_en SHALL shift S right by W with fill (sign bit for I/S/B/J, 0 for U) and increment beat.
REQ-011 i_imm_fmt SHALL be sampled only on the READY->SHIFT transition; later changes SHALL be ignored until the next i_wb_en.
REQ-012 i_cnt_en at beat C-1 SHALL enter DRAINED; in DRAINED, o_imm SHALL be all fill bits and further i_cnt_en SHALL be ignored.
REQ-013 o_last SHALL be 1 when in READY or SHIFT with beat == C-1.
REQ-014 o_csr_imm SHALL shift the zero-extended 5-bit zimm instr[19:15] in lockstep with o_imm, zero-filled, and SHALL read 0 whenever i_csr_imm_en = 0.
REQ-015 If i_cnt_done and i_cnt_en are both high while beat != C-1, o_misalign SHALL set the next cycle and hold until i_wb_en or reset.
REQ-016 If i_wb_en and i_cnt_en are both high in the same cycle, i_wb_en SHALL win: the block loads the new instruction and does not shift.
REQ-017 In IDLE, i_cnt_en SHALL be ignored and o_imm and o_csr_imm SHALL be 0.
REQ-018 Latency SHALL be: addresses valid one cycle after i_wb_en; o_imm valid in READY with no added beat latency.

Reset
REQ-019 While i_rst_n = 0, the block SHALL asynchronously clear all registers: state IDLE, beat 0, S 0, raw 0.
REQ-020 During and after reset, all outputs SHALL be 0 until the next i_wb_en.
REQ-021 A reset asserted mid-SHIFT SHALL abort the sequence with no residual beat state.

Verification
REQ-022 The bench SHALL cover at least these scenarios:
- W=8, wb 0x12300093, fmt I, 4 beats -> o_imm 23,01,00,00; rd=1, rs1=0, rs2=3; o_last high on beat 4 only.
- W=8, wb 0xABCDE2B7, fmt U -> o_imm 00,E0,CD,AB; rd=5; DRAINED afterwards gives o_imm 00.
- W=8, S-type imm -8 -> o_imm F8,FF,FF,FF; DRAINED gives FF; fmt changed mid-sequence -> no effect.
- W=1, csrrwi with zimm 0x1F, i_csr_imm_en=1 -> o_csr_imm 1,1,1,1,1 then 27 zeros; with i_csr_imm_en=0 -> all 0.
- W=4, i_cnt_done with i_cnt_en at beat 2 -> o_misalign=1 next cycle, held until next i_wb_en clears it; i_wb_en together with i_cnt_en -> beat 0, no shift.
- W=8, i_rst_n low at beat 2 -> all outputs 0 and state IDLE immediately; i_cnt_en ignored until i_wb_en.
